// File: rtl/seg_scan_driver.sv
// Six-digit time-multiplexed 7-segment driver: shadowed digits, free-running
// slot prescaler, per-digit decode/blank lanes, registered active-low outputs.

module seg_lane #(
  parameter bit LAST = 1'b0
) (
  input  logic [3:0] digit,
  input  logic       lead_zero,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       zero_out
);
  logic [6:0] dec;
  logic       blank;

  always_comb begin
    dec = 7'h7F;
    unique case (digit)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
      default: dec = 7'h7F;
    endcase
  end

  // lead_zero means every more-significant digit is zero; the last digit is never blanked
  assign zero_out = lead_zero && (digit == 4'h0);
  assign blank    = !LAST && blank_lz && zero_out;
  assign seg      = blank ? 7'h7F : dec;
endmodule

module seg_scan_driver #(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_done
);
  localparam int NUM_LANES = 6;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [2:0] POS_FIRST = 3'd0;
  localparam logic [2:0] POS_LAST  = 3'd5;

  logic [CW-1:0]                  cnt;
  logic                           tick;
  logic [2:0]                     pos, pos_next;
  logic [NUM_LANES-1:0][3:0]      sh;
  logic [NUM_LANES-1:0][6:0]      lane_seg;
  logic [NUM_LANES:0]             zchain;

  assign tick     = (cnt == CW'(CLK_DIV - 1));
  assign pos_next = (pos == POS_LAST) ? POS_FIRST : pos + 3'd1;
  assign zchain[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      seg_lane #(.LAST(i == NUM_LANES - 1)) u_lane (
        .digit    (sh[i]),
        .lead_zero(zchain[i]),
        .blank_lz (blank_lz),
        .seg      (lane_seg[i]),
        .zero_out (zchain[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  // Shadow is written non-blocking, so a load on a tick edge still shows old data this slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh <= '0;
    end else if (load) begin
      sh <= {d6, d5, d4, d3, d2, d1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos        <= POS_LAST;
      seg        <= 7'h7F;
      an         <= 6'h3F;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (pos == POS_LAST);
      if (tick) begin
        pos <= pos_next;
        seg <= lane_seg[pos_next];
        an  <= ~(NUM_LANES'(1) << pos_next);
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized scoreboard bench for seg_scan_driver: a slot-level reference model
// pushes the expected outputs every cycle, a monitor pops and compares.

module tb_seg_scan_driver;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] dv [6];
  logic       blank_lz;
  logic [6:0] seg;
  logic [5:0] an;
  logic       frame_done;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .d1(dv[0]), .d2(dv[1]), .d3(dv[2]), .d4(dv[3]), .d5(dv[4]), .d6(dv[5]),
    .blank_lz(blank_lz), .seg(seg), .an(an), .frame_done(frame_done)
  );

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // Reference model: cycles since reset decide slot boundaries, slots advance d1..d6 cyclically
  int         m_cyc;
  int         m_slot;
  logic [3:0] m_sh [6];
  exp_t       m_cur;

  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_cyc  = 0;
      m_slot = -1;
      for (int k = 0; k < 6; k++) m_sh[k] = 4'h0;
      m_cur = '{an: 6'h3F, seg: 7'h7F, fd: 1'b0};
    end else begin
      m_cyc++;
      m_cur.fd = 1'b0;
      if (m_cyc % CLK_DIV == 0) begin
        int  dig;
        int  lead_sum;
        dig = (m_slot + 1) % 6;
        m_slot = dig;
        lead_sum = 0;
        for (int k = 0; k <= dig; k++) lead_sum += int'(m_sh[k]);
        m_cur.an  = 6'h3F ^ (6'(1) << dig);
        m_cur.seg = (blank_lz && dig < 5 && lead_sum == 0) ? 7'h7F : hex7(m_sh[dig]);
        m_cur.fd  = (dig == 0);
      end
      if (load) for (int k = 0; k < 6; k++) m_sh[k] = dv[k];
    end
    e = m_cur;
    q.push_back(e);
  end

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL scoreboard_empty at %0t: an=%h seg=%h fd=%b with nothing expected",
                 $time, an, seg, frame_done);
      end else begin
        e = q.pop_front();
        if ({an, seg, frame_done} !== e) begin
          nerr++;
          $display("FAIL slot_outputs at %0t: got an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                   $time, an, seg, frame_done, e.an, e.seg, e.fd);
        end
      end
      if (an !== 6'h3F) begin
        nvec++;
        if ($countones(~an) != 1) begin
          nerr++;
          $display("FAIL anode_onehot at %0t: got an=%b expected exactly one low bit", $time, an);
        end
      end
    end
  end

  task automatic set_digits(input logic [23:0] v, input logic bl);
    @(negedge clk);
    for (int k = 0; k < 6; k++) dv[k] = v[23-4*k -: 4];
    blank_lz = bl;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    blank_lz = 1'b0;
    for (int k = 0; k < 6; k++) dv[k] = 4'h0;
    idle(3);
    rst_n = 1'b1;
    idle(8);

    set_digits(24'h123456, 1'b0);  idle(30);
    set_digits(24'h000023, 1'b1);  idle(26);
    set_digits(24'h000000, 1'b1);  idle(26);
    set_digits(24'hABCDEF, 1'b0);  idle(26);

    // Load held across several edges so it coincides with slot boundaries
    for (int k = 0; k < 6; k++) dv[k] = 4'h1;
    load = 1'b1; blank_lz = 1'b0;
    idle(1);
    dv[1] = 4'h9;
    idle(6);
    load = 1'b0;
    idle(30);

    // Reset partway through a frame
    idle(14);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(30);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 6; k++)
        dv[k] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    load = 1'b0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
